btn_conditioner: RTL and testbench

- Front-end conditioner for the board push-button that steps the accelerator's result viewer.
- Takes the raw asynchronous pad signal and synchronises and debounces it.
- Produces the btn_prev / btn_edge pair consumed by main, with optional hold-to-auto-repeat so a held button scrolls through result words.
- Sits between the FPGA pin and main; one instance per button.

---
 rtl/btn_conditioner.sv | 158 +++++++++++++++
 tb/tb_btn_conditioner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button front end: synchroniser, debounce FSM, optional auto-repeat,
// and the btn_prev/btn_edge pair plus a press counter.
module btn_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          AUTO_REPEAT_EN  = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       btn_prev,
  output logic       btn_edge,
  output logic       btn_release,
  output logic [7:0] press_count
);

  localparam int unsigned MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CYC = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

  // The IDLE sample is the first stable sample, so the counter (cleared on
  // entry) reaches DEBOUNCE_CYCLES-2 on the last required sample.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] RD_LOAD  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RR_LOAD  = CW'(REPEAT_RATE);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_btn;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic          level_q, level_d;
  logic          prev_q;
  logic          edge_q, edge_d;
  logic          rel_q, rel_d;
  logic [7:0]    count_q, count_d;

  logic          tmr_expire;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] tmr_next;

  assign sync_btn   = sync_q[SYNC_STAGES-1];
  assign tmr_expire = (tmr_q == CW'(1));
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  // Repeat timer keeps running while held or release-bouncing; reloads on expiry.
  assign tmr_next   = tmr_expire ? RR_LOAD : ((tmr_q != '0) ? tmr_q - CW'(1) : tmr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    level_d = level_q;
    edge_d  = 1'b0;
    rel_d   = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (sync_btn) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_btn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          edge_d  = 1'b1;
          count_d = count_q + 8'd1;
          tmr_d   = RD_LOAD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        tmr_d = tmr_next;
        if (AUTO_REPEAT_EN && tmr_expire) begin
          edge_d = 1'b1;
        end
        if (!sync_btn) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        tmr_d = tmr_next;
        if (sync_btn) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmr_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
      rel_q   <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      level_q <= level_d;
      prev_q  <= level_q;
      edge_q  <= edge_d;
      rel_q   <= rel_d;
      count_q <= count_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_prev    = prev_q;
  assign btn_edge    = edge_q;
  assign btn_release = rel_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: a per-cycle vector table for a clean
// press plus hand-written sequences for bounce, repeat, wrap and reset.
module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic       raw1, raw2;
  logic       lvl1, prv1, edg1, rel1;
  logic [7:0] cnt1;
  logic       lvl2, prv2, edg2, rel2;
  logic [7:0] cnt2;

  int n_vec = 0;
  int n_err = 0;
  logic both_seen = 1'b0;

  btn_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .AUTO_REPEAT_EN(1'b1),
    .REPEAT_DELAY(20), .REPEAT_RATE(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(raw1),
    .btn_level(lvl1), .btn_prev(prv1), .btn_edge(edg1),
    .btn_release(rel1), .press_count(cnt1)
  );

  btn_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .AUTO_REPEAT_EN(1'b0),
    .REPEAT_DELAY(20), .REPEAT_RATE(8)
  ) dut_norep (
    .clk(clk), .rst(rst), .btn_raw(raw2),
    .btn_level(lvl2), .btn_prev(prv2), .btn_edge(edg2),
    .btn_release(rel2), .press_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((edg1 && rel1) || (edg2 && rel2)) both_seen = 1'b1;
  end

  typedef struct {
    logic       raw;
    logic       lvl;
    logic       prv;
    logic       edg;
    logic       rel;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int q[$];
    int exp_ar[6];
    int rel_at;
    int rel_n;
    int edge_n;
    int rel2_n;
    logic lvl_drop;
    logic any_bad;

    // Clean press: raw rises before table edge 0, accepted after edge 5,
    // released before edge 12 and dropped after edge 17.
    for (int i = 0; i < 20; i++) begin
      tbl[i].raw = (i < 12);
      tbl[i].lvl = (i >= 5) && (i < 17);
      tbl[i].prv = (i >= 6) && (i < 18);
      tbl[i].edg = (i == 5);
      tbl[i].rel = (i == 17);
      tbl[i].cnt = (i >= 5) ? 8'd1 : 8'd0;
    end
    exp_ar = '{5, 25, 33, 41, 49, 57};

    rst = 1'b0; raw1 = 1'b0; raw2 = 1'b0;
    tick(); tick();
    chk("reset_state", {20'd0, lvl1, prv1, edg1, rel1, cnt1}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("idle_after_reset", {20'd0, lvl1, prv1, edg1, rel1, cnt1}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      raw1 = tbl[i].raw;
      tick();
      chk($sformatf("clean_vec%0d", i),
          {20'd0, lvl1, prv1, edg1, rel1, cnt1},
          {20'd0, tbl[i].lvl, tbl[i].prv, tbl[i].edg, tbl[i].rel, tbl[i].cnt});
    end

    // Bounce: 3 high / 2 low never reaches 4 stable samples.
    any_bad = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        raw1 = (c < 3);
        tick();
        if (lvl1 || edg1 || cnt1 != 8'd1) any_bad = 1'b1;
      end
    end
    raw1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (lvl1 || edg1 || cnt1 != 8'd1) any_bad = 1'b1;
    end
    chk("bounce_no_activity", {31'd0, any_bad}, 32'd0);
    chk("bounce_count", {24'd0, cnt1}, 32'd1);

    // Auto-repeat: held 60 cycles, release; the expiry during release is swallowed.
    q.delete();
    raw1 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (edg1) q.push_back(k);
    end
    raw1 = 1'b0;
    rel_at = -1;
    rel_n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (edg1) q.push_back(60 + k);
      if (rel1) begin
        rel_n++;
        if (rel_at < 0) rel_at = k;
      end
      if (k == 4) chk("ar_level_before_release", {31'd0, lvl1}, 32'd1);
      if (k == 5) chk("ar_level_after_release", {31'd0, lvl1}, 32'd0);
    end
    chk("ar_edge_total", q.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ar_edge%0d_cycle", i), (i < q.size()) ? q[i] : -1, exp_ar[i]);
    end
    chk("ar_release_cycle", rel_at, 32'd5);
    chk("ar_release_width", rel_n, 32'd1);
    chk("ar_press_count", {24'd0, cnt1}, 32'd2);

    // Release bounce: 3 low cycles while held must not disturb level or repeat timing.
    q.delete();
    rel_n = 0;
    lvl_drop = 1'b0;
    for (int k = 0; k < 31; k++) begin
      raw1 = !((k >= 10) && (k <= 12));
      tick();
      if (edg1) q.push_back(k);
      if (rel1) rel_n++;
      if (k >= 5 && !lvl1) lvl_drop = 1'b1;
    end
    chk("rb_no_release", rel_n, 32'd0);
    chk("rb_level_held", {31'd0, lvl_drop}, 32'd0);
    chk("rb_edge_total", q.size(), 32'd2);
    chk("rb_repeat_cycle", (q.size() > 1) ? q[1] : -1, 32'd25);
    raw1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rel1) rel_n++;
    end
    chk("rb_final_release", rel_n, 32'd1);
    chk("rb_press_count", {24'd0, cnt1}, 32'd3);

    // No auto-repeat: one edge for a long hold, then the counter wraps after 256 presses.
    q.delete();
    raw2 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (edg2) q.push_back(k);
    end
    chk("norep_single_edge", q.size(), 32'd1);
    chk("norep_edge_cycle", (q.size() > 0) ? q[0] : -1, 32'd5);
    chk("norep_count1", {24'd0, cnt2}, 32'd1);
    edge_n = 1;
    rel2_n = 0;
    raw2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rel2) rel2_n++;
    end
    for (int p = 1; p < 256; p++) begin
      for (int k = 0; k < 16; k++) begin
        raw2 = (k < 8);
        tick();
        if (edg2) edge_n++;
        if (rel2) rel2_n++;
      end
      if (p == 254) chk("wrap_count255", {24'd0, cnt2}, 32'd255);
    end
    chk("wrap_edges", edge_n, 32'd256);
    chk("wrap_releases", rel2_n, 32'd256);
    chk("wrap_count0", {24'd0, cnt2}, 32'd0);

    // Reset while held: outputs clear at once; raw still high is a fresh press.
    raw1 = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("pre_reset_held", {31'd0, lvl1}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_clear", {20'd0, lvl1, prv1, edg1, rel1, cnt1}, 32'd0);
    tick(); tick();
    chk("reset_hold_clear", {20'd0, lvl1, prv1, edg1, rel1, cnt1}, 32'd0);
    rst = 1'b1;
    q.delete();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (edg1) q.push_back(k);
    end
    chk("post_reset_edge_cycle", (q.size() > 0) ? q[0] : -1, 32'd5);
    chk("post_reset_count", {24'd0, cnt1}, 32'd1);

    chk("edge_release_exclusive", {31'd0, both_seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
